// File: rtl/chess_layout_renderer.sv
// Snapshots the flattened chess Layout once per frame and streams RGB565 pixels to the LCD writer.
// Define CURSOR_BLINK_EN to blink cursor borders every BLINK_FRAMES frames.
module chess_layout_renderer #(
    parameter int CHESS_SQUARES  = 64,
    parameter int SQUARE_WIDTH   = 8,
    parameter int DISPLAY_WIDTH  = 240,
    parameter int DISPLAY_HEIGHT = 320,
    parameter int SQUARE_PIXELS  = 30,
    parameter int BOARD_Y_OFFSET = 40,
    parameter int BLINK_FRAMES   = 16
) (
    input  logic                                  clock,
    input  logic                                  resetApp,
    input  logic [CHESS_SQUARES*SQUARE_WIDTH-1:0] Layout,
    input  logic                                  pixelReady,
    output logic                                  pixelWrite,
    output logic [15:0]                           pixelData,
    output logic                                  pixelFirst
);

    localparam int X_W   = $clog2(DISPLAY_WIDTH);
    localparam int Y_W   = $clog2(DISPLAY_HEIGHT);
    localparam int SUB_W = $clog2(SQUARE_PIXELS);

    localparam logic [X_W-1:0]   X_LAST     = X_W'(DISPLAY_WIDTH - 1);
    localparam logic [Y_W-1:0]   Y_LAST     = Y_W'(DISPLAY_HEIGHT - 1);
    localparam logic [Y_W-1:0]   Y_TOP      = Y_W'(BOARD_Y_OFFSET);
    localparam logic [Y_W-1:0]   Y_BOT      = Y_W'(BOARD_Y_OFFSET + 8 * SQUARE_PIXELS);
    localparam logic [SUB_W-1:0] SUB_LAST   = SUB_W'(SQUARE_PIXELS - 1);
    localparam logic [SUB_W-1:0] BORDER_LO  = SUB_W'(2);
    localparam logic [SUB_W-1:0] BORDER_HI  = SUB_W'(SQUARE_PIXELS - 3);
    localparam logic [SUB_W-1:0] INSET_LO   = SUB_W'(8);
    localparam logic [SUB_W-1:0] INSET_HI   = SUB_W'(SQUARE_PIXELS - 9);

    localparam logic [15:0] C_BACKGROUND = 16'h0000;
    localparam logic [15:0] C_LOCKED_CUR = 16'hF800;
    localparam logic [15:0] C_CURSOR     = 16'h07E0;
    localparam logic [15:0] C_WHITE_PC   = 16'hFFFF;
    localparam logic [15:0] C_BLACK_PC   = 16'h2104;
    localparam logic [15:0] C_LOCKED_SRC = 16'hFFE0;
    localparam logic [15:0] C_LIGHT_SQ   = 16'hDEFB;
    localparam logic [15:0] C_DARK_SQ    = 16'h8410;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LATCH,
        S_STREAM,
        S_FRAME_END
    } state_t;

    state_t state_q, state_d;

    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [SUB_W-1:0] sub_x_q, sub_x_d;
    logic [SUB_W-1:0] sub_y_q, sub_y_d;
    logic [2:0]       col_q, col_d;
    logic [2:0]       row_q, row_d;

    logic [CHESS_SQUARES-1:0][SQUARE_WIDTH-1:0] snap_q;

    logic streaming;
    logic xfer;
    logic last_pixel;
    logic board_line;
    logic cursor_vis;

    assign streaming  = (state_q == S_STREAM);
    assign xfer       = streaming && pixelReady;
    assign last_pixel = (x_q == X_LAST) && (y_q == Y_LAST);
    assign board_line = (y_q >= Y_TOP) && (y_q < Y_BOT);

    // Priority colour of one on-board pixel from its square entry and in-square position.
    function automatic logic [15:0] square_colour(
        input logic [SQUARE_WIDTH-1:0] sq,
        input logic [SUB_W-1:0]        sx,
        input logic [SUB_W-1:0]        sy,
        input logic [2:0]              row,
        input logic [2:0]              col,
        input logic                    show_cursor
    );
        logic        border;
        logic        inset;
        logic [15:0] c;
        border = (sx < BORDER_LO) || (sx > BORDER_HI) || (sy < BORDER_LO) || (sy > BORDER_HI);
        inset  = (sx >= INSET_LO) && (sx <= INSET_HI) && (sy >= INSET_LO) && (sy <= INSET_HI);
        if (border && show_cursor && sq[6]) begin
            c = C_LOCKED_CUR;
        end else if (border && show_cursor && sq[4]) begin
            c = C_CURSOR;
        end else if (inset && (sq[2:0] != 3'd0)) begin
            c = sq[3] ? C_WHITE_PC : C_BLACK_PC;
        end else if (sq[5]) begin
            c = C_LOCKED_SRC;
        end else if (row[0] ^ col[0]) begin
            c = C_DARK_SQ;
        end else begin
            c = C_LIGHT_SQ;
        end
        return c;
    endfunction

    always_ff @(posedge clock) begin
        if (resetApp) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            sub_x_q <= '0;
            sub_y_q <= '0;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sub_x_q <= sub_x_d;
            sub_y_q <= sub_y_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    // The snapshot is pure data: it is only ever read after a LATCH cycle has filled it.
    always_ff @(posedge clock) begin
        if (state_q == S_LATCH) begin
            snap_q <= Layout;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      state_d = S_LATCH;
            S_LATCH:     state_d = S_STREAM;
            S_STREAM:    if (xfer && last_pixel) state_d = S_FRAME_END;
            S_FRAME_END: state_d = S_LATCH;
            default:     state_d = S_IDLE;
        endcase
    end

    // Raster counters; square row/col only advance on board lines so no division is needed.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        sub_x_d = sub_x_q;
        sub_y_d = sub_y_q;
        col_d   = col_q;
        row_d   = row_q;
        if (xfer) begin
            if (x_q == X_LAST) begin
                x_d     = '0;
                sub_x_d = '0;
                col_d   = '0;
                if (y_q == Y_LAST) begin
                    y_d     = '0;
                    sub_y_d = '0;
                    row_d   = '0;
                end else begin
                    y_d = y_q + 1'b1;
                    if (board_line) begin
                        if (sub_y_q == SUB_LAST) begin
                            sub_y_d = '0;
                            row_d   = row_q + 1'b1;
                        end else begin
                            sub_y_d = sub_y_q + 1'b1;
                        end
                    end
                end
            end else begin
                x_d = x_q + 1'b1;
                if (sub_x_q == SUB_LAST) begin
                    sub_x_d = '0;
                    col_d   = col_q + 1'b1;
                end else begin
                    sub_x_d = sub_x_q + 1'b1;
                end
            end
        end
    end

`ifdef CURSOR_BLINK_EN
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

    logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
    logic            blink_hide_q, blink_hide_d;

    always_comb begin
        frame_cnt_d  = frame_cnt_q;
        blink_hide_d = blink_hide_q;
        if (state_q == S_FRAME_END) begin
            if (frame_cnt_q == FC_LAST) begin
                frame_cnt_d  = '0;
                blink_hide_d = ~blink_hide_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (resetApp) begin
            frame_cnt_q  <= '0;
            blink_hide_q <= 1'b0;
        end else begin
            frame_cnt_q  <= frame_cnt_d;
            blink_hide_q <= blink_hide_d;
        end
    end

    assign cursor_vis = ~blink_hide_q;
`else
    assign cursor_vis = 1'b1;
`endif

    // Outputs depend only on registered state, so they hold steady while the LCD stalls.
    always_comb begin
        pixelWrite = streaming;
        pixelFirst = streaming && (x_q == '0) && (y_q == '0);
        pixelData  = C_BACKGROUND;
        if (streaming && board_line) begin
            pixelData = square_colour(snap_q[{row_q, col_q}], sub_x_q, sub_y_q,
                                      row_q, col_q, cursor_vis);
        end
    end

endmodule

// File: tb/tb_chess_layout_renderer.sv
// Directed bench for chess_layout_renderer: reset timing, one full frame, frame gap,
// stall hold, snapshot isolation and mid-frame reset restart.
module tb_chess_layout_renderer;

    logic         clock = 1'b0;
    logic         resetApp = 1'b1;
    logic [511:0] layout = '0;
    logic         pixelReady = 1'b0;
    logic         pixelWrite;
    logic [15:0]  pixelData;
    logic         pixelFirst;

    chess_layout_renderer dut (
        .clock      (clock),
        .resetApp   (resetApp),
        .Layout     (layout),
        .pixelReady (pixelReady),
        .pixelWrite (pixelWrite),
        .pixelData  (pixelData),
        .pixelFirst (pixelFirst)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    int fr          = 0;
    int pos         = 0;
    int xfers       = 0;
    int gap         = 0;
    int first_bad   = 0;
    int outside_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_sq(input int idx, input logic [7:0] v);
        layout[idx*8 +: 8] = v;
    endtask

    function automatic int at(input int x, input int y);
        return y * 240 + x;
    endfunction

    task automatic pixel_checks();
        if (fr == 0) begin
            if (pos == at(3, 43))    check("light_sq_3_43", pixelData, 16'hDEFB);
            if (pos == at(33, 43))   check("dark_sq_33_43", pixelData, 16'h8410);
            if (pos == at(7, 48))    check("inset_edge_7_48", pixelData, 16'hDEFB);
            if (pos == at(8, 48))    check("inset_edge_8_48", pixelData, 16'hFFFF);
            if (pos == at(15, 55))   check("white_pawn_15_55", pixelData, 16'hFFFF);
            if (pos == at(16, 55))   check("after_stall_16_55", pixelData, 16'hFFFF);
            if (pos == at(32, 72))   check("locked_src_32_72", pixelData, 16'hFFE0);
            if (pos == at(59, 130))  check("border_sq25_59_130", pixelData, 16'hDEFB);
            if (pos == at(60, 130))  check("cursor_60_130", pixelData, 16'h07E0);
            if (pos == at(62, 131))  check("cursor_sy1_62_131", pixelData, 16'h07E0);
            if (pos == at(62, 132))  check("no_border_62_132", pixelData, 16'h8410);
            if (pos == at(90, 130))  check("locked_cur_90_130", pixelData, 16'hF800);
            if (pos == at(0, 279))   check("last_board_line_0_279", pixelData, 16'h8410);
        end else if (fr == 1) begin
            if (pos == at(15, 55))   check("new_black_pc_15_55", pixelData, 16'h2104);
            if (pos == at(32, 72))   check("new_empty_32_72", pixelData, 16'hDEFB);
        end
    endtask

    task automatic stall_here();
        int n;
        n = $urandom_range(7, 3);
        pixelReady = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            @(negedge clock);
            check("stall_data", pixelData, 16'hFFFF);
            check("stall_write", pixelWrite, 1'b1);
        end
    endtask

    // Streams with pixelReady high (except one stall), tracking the raster position,
    // until the pixel at (stop_fr, stop_pos) is presented.
    task automatic run_to(input int stop_fr, input int stop_pos, input int budget);
        int  cycles;
        bit  done;
        cycles = 0;
        done   = 1'b0;
        while (!done && cycles < budget) begin
            if (pixelWrite && fr == stop_fr && pos == stop_pos) begin
                done = 1'b1;
            end else begin
                if (pixelWrite) begin
                    if (pixelFirst !== (pos == 0)) first_bad++;
                    if (((pos / 240) < 40 || (pos / 240) >= 280) && pixelData !== 16'h0000)
                        outside_bad++;
                    pixel_checks();
                    if (fr == 0 && pos == at(15, 55)) stall_here();
                    if (fr == 0 && pos == at(0, 100)) begin
                        set_sq(0, 8'h03);
                        set_sq(9, 8'h00);
                        set_sq(26, 8'h52);
                    end
                    pixelReady = 1'b1;
                    @(posedge clock);
                    pos++;
                    xfers++;
                    if (pos == 76800) begin
                        check("xfers_per_frame", xfers, 76800);
                        check("first_flag_placement", first_bad, 0);
                        check("outside_board_black", outside_bad, 0);
                        pos         = 0;
                        fr++;
                        xfers       = 0;
                        gap         = 0;
                        first_bad   = 0;
                        outside_bad = 0;
                    end
                end else begin
                    pixelReady = 1'b1;
                    gap++;
                    @(posedge clock);
                end
                @(negedge clock);
                cycles++;
            end
        end
        if (!done) check("run_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        resetApp   = 1'b1;
        pixelReady = 1'b1;
        set_sq(0, 8'h09);
        set_sq(9, 8'h21);
        set_sq(26, 8'h12);
        set_sq(27, 8'h52);
        repeat (3) @(negedge clock);
        check("rst_write", pixelWrite, 1'b0);
        check("rst_first", pixelFirst, 1'b0);
        check("rst_data", pixelData, 16'h0000);

        resetApp = 1'b0;
        @(negedge clock);
        check("latch_write", pixelWrite, 1'b0);
        @(negedge clock);
        check("start_write", pixelWrite, 1'b1);
        check("start_first", pixelFirst, 1'b1);
        check("start_data", pixelData, 16'h0000);

        run_to(1, 0, 77000);
        check("frame_gap", gap, 2);
        check("frame2_first", pixelFirst, 1'b1);
        check("frame2_data", pixelData, 16'h0000);

        run_to(1, at(0, 60), 15000);
        resetApp = 1'b1;
        @(negedge clock);
        check("midrst_write", pixelWrite, 1'b0);
        check("midrst_first", pixelFirst, 1'b0);
        check("midrst_data", pixelData, 16'h0000);
        resetApp = 1'b0;
        @(negedge clock);
        check("restart_latch", pixelWrite, 1'b0);
        @(negedge clock);
        check("restart_write", pixelWrite, 1'b1);
        check("restart_first", pixelFirst, 1'b1);
        check("restart_data", pixelData, 16'h0000);
        pixelReady = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("restart_next_first", pixelFirst, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
